lot_gate_ctrl: RTL and testbench

Entry-barrier and occupancy controller for the parking lot. It consumes the single-cycle car-entered (`car_in`) and car-exited (`car_out`) pulses produced by the lane sensor FSM and tracks lot occupancy against a fixed capacity. It serves gate requests from the entry pushbutton and sequences the barrier through open, pass and close phases. It sits directly downstream of the sensor FSM and drives the barrier actuator and the "LOT FULL" sign.

---
 rtl/parking_pkg.sv | 20 ++
 rtl/occ_counter.sv | 59 +++++
 rtl/lot_gate_ctrl.sv | 115 +++++++++++
 tb/tb_lot_gate_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared parking-lot types: gate FSM state encoding and lane sensor codes.
`default_nettype none

package parking_pkg;

  typedef enum logic [1:0] {
    GATE_IDLE    = 2'd0,
    GATE_OPEN    = 2'd1,
    GATE_CLOSING = 2'd2
  } gate_state_t;

  // Lane sensor {a,b} codes, common to this block and the lane sensor FSM
  localparam logic [1:0] AB_CLEAR = 2'b00;
  localparam logic [1:0] AB_A     = 2'b10;
  localparam logic [1:0] AB_BOTH  = 2'b11;
  localparam logic [1:0] AB_B     = 2'b01;

endpackage

`default_nettype wire

// File: rtl/occ_counter.sv
// Saturating occupancy counter with full/empty decode and sticky error flags.
`default_nettype none

module occ_counter #(
  parameter int CAPACITY = 16,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_udf
);

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);

  logic at_cap;
  logic at_zero;

  assign at_cap  = (count == CAP);
  assign at_zero = (count == '0);

  // Simultaneous in/out cancel and are never treated as an overflow or underflow
  always_comb begin
    count_next = count;
    if (inc && !dec && !at_cap) begin
      count_next = count + CNT_W'(1);
    end else if (dec && !inc && !at_zero) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count   <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      count <= count_next;
      if (inc && !dec && at_cap) begin
        err_ovf <= 1'b1;
      end
      if (dec && !inc && at_zero) begin
        err_udf <= 1'b1;
      end
    end
  end

  assign full  = at_cap;
  assign empty = at_zero;

endmodule

`default_nettype wire

// File: rtl/lot_gate_ctrl.sv
// Parking-lot entry barrier sequencer and occupancy tracker.
`default_nettype none

module lot_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY     = 16,
  parameter int CNT_W        = $clog2(CAPACITY + 1),
  parameter int GATE_TIMEOUT = 50,
  parameter int TO_W         = $clog2(GATE_TIMEOUT)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic             car_in,
  input  logic             car_out,
  output logic             gate_open,
  output logic             deny,
  output logic             timeout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_udf
);

  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(GATE_TIMEOUT - 1);

  gate_state_t      state;
  gate_state_t      state_next;
  logic [TO_W-1:0]  timer;
  logic [TO_W-1:0]  timer_next;
  logic             deny_next;
  logic             timeout_next;
  logic [CNT_W-1:0] count_next;

  occ_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occ_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc        (car_in),
    .dec        (car_out),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty),
    .err_ovf    (err_ovf),
    .err_udf    (err_udf)
  );

  always_comb begin
    state_next   = state;
    timer_next   = timer;
    deny_next    = 1'b0;
    timeout_next = 1'b0;
    case (state)
      GATE_IDLE: begin
        timer_next = '0;
        // Grant decision uses count_next so a coincident car_in is accounted for
        if (req) begin
          if (count_next < CAP) begin
            state_next = GATE_OPEN;
          end else begin
            deny_next  = 1'b1;
            state_next = GATE_CLOSING;
          end
        end
      end
      GATE_OPEN: begin
        if (car_in) begin
          state_next = GATE_CLOSING;
          timer_next = '0;
        end else if (timer == TO_LAST) begin
          timeout_next = 1'b1;
          state_next   = GATE_CLOSING;
          timer_next   = '0;
        end else begin
          timer_next = timer + TO_W'(1);
        end
      end
      GATE_CLOSING: begin
        timer_next = '0;
        if (!req) begin
          state_next = GATE_IDLE;
        end
      end
      default: begin
        state_next = GATE_IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= GATE_IDLE;
      timer     <= '0;
      gate_open <= 1'b0;
      deny      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      timer     <= timer_next;
      gate_open <= (state_next == GATE_OPEN);
      deny      <= deny_next;
      timeout   <= timeout_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lot_gate_ctrl.sv
// Randomized and directed bench for lot_gate_ctrl against a cycle-level behavioural model.
`default_nettype none

module tb_lot_gate_ctrl;

  localparam int CAP   = 4;
  localparam int GT    = 8;
  localparam int CNT_W = $clog2(CAP + 1);
  localparam int TO_W  = $clog2(GT);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req = 1'b0;
  logic             car_in = 1'b0;
  logic             car_out = 1'b0;
  logic             gate_open;
  logic             deny;
  logic             timeout;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             err_ovf;
  logic             err_udf;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = waiting for a press, 1 = barrier up, 2 = waiting for release
  int m_cnt = 0;
  int m_phase = 0;
  int m_left = 0;
  bit m_deny = 0;
  bit m_to = 0;
  bit m_ovf = 0;
  bit m_udf = 0;

  lot_gate_ctrl #(
    .CAPACITY     (CAP),
    .CNT_W        (CNT_W),
    .GATE_TIMEOUT (GT),
    .TO_W         (TO_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .car_in    (car_in),
    .car_out   (car_out),
    .gate_open (gate_open),
    .deny      (deny),
    .timeout   (timeout),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .err_ovf   (err_ovf),
    .err_udf   (err_udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge
  task automatic cycle(input bit rq, input bit ci, input bit co, input bit rn = 1'b1);
    int nxt;
    req     = rq;
    car_in  = ci;
    car_out = co;
    reset_n = rn;
    if (!rn) begin
      m_cnt = 0; m_phase = 0; m_left = 0;
      m_deny = 0; m_to = 0; m_ovf = 0; m_udf = 0;
    end else begin
      nxt = m_cnt + (ci ? 1 : 0) - (co ? 1 : 0);
      if (nxt > CAP) begin nxt = CAP; m_ovf = 1; end
      if (nxt < 0)   begin nxt = 0;   m_udf = 1; end
      m_deny = 0;
      m_to   = 0;
      if (m_phase == 0) begin
        if (rq && nxt < CAP) begin m_phase = 1; m_left = GT; end
        else if (rq) begin m_deny = 1; m_phase = 2; end
      end else if (m_phase == 1) begin
        m_left = m_left - 1;
        if (ci) m_phase = 2;
        else if (m_left == 0) begin m_to = 1; m_phase = 2; end
      end else if (!rq) begin
        m_phase = 0;
      end
      m_cnt = nxt;
    end
    @(posedge clk);
    #1;
    check("gate_open", int'(gate_open), (m_phase == 1) ? 1 : 0);
    check("deny", int'(deny), int'(m_deny));
    check("timeout", int'(timeout), int'(m_to));
    check("count", int'(count), m_cnt);
    check("full", int'(full), (m_cnt == CAP) ? 1 : 0);
    check("empty", int'(empty), (m_cnt == 0) ? 1 : 0);
    check("err_ovf", int'(err_ovf), int'(m_ovf));
    check("err_udf", int'(err_udf), int'(m_udf));
  endtask

  initial begin
    int opens;
    int tos;
    int denies;
    bit rq, ci, co, rn;

    #2;
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("reset_count", int'(count), 0);
    check("reset_empty", int'(empty), 1);

    // Normal entry: open for two cycles, car enters on the second
    cycle(1, 0, 0);
    check("s1_open", int'(gate_open), 1);
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    check("s1_closed", int'(gate_open), 0);
    check("s1_count", int'(count), 1);
    cycle(0, 0, 0);

    // Timeout: barrier up exactly GT cycles, one timeout pulse
    opens = 0; tos = 0;
    cycle(1, 0, 0);
    opens += int'(gate_open);
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0);
      opens += int'(gate_open);
      tos   += int'(timeout);
    end
    check("s2_open_cycles", opens, GT);
    check("s2_timeouts", tos, 1);
    check("s2_count", int'(count), 1);

    // Fill to capacity then press: single deny, barrier stays down
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      cycle(0, 1, 0);
      cycle(0, 0, 0);
    end
    check("s3_full", int'(full), 1);
    denies = 0; opens = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0);
      denies += int'(deny);
      opens  += int'(gate_open);
    end
    check("s3_denies", denies, 1);
    check("s3_no_open", opens, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(1, 0, 0);
    check("s3_regrant", int'(gate_open), 1);
    cycle(0, 1, 0);
    cycle(0, 0, 0);

    // Simultaneous pulses and same-cycle request/entry at CAP-1
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 1);
    check("s4_both", int'(count), 2);
    cycle(0, 1, 0);
    cycle(1, 1, 0);
    check("s4_deny", int'(deny), 1);
    check("s4_count", int'(count), CAP);
    cycle(0, 0, 0);

    // Sticky error flags
    cycle(0, 1, 0);
    check("s5_ovf", int'(err_ovf), 1);
    check("s5_ovf_count", int'(count), CAP);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1);
    check("s5_udf", int'(err_udf), 1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0);
    cycle(0, 0, 1);
    check("s5_both_sticky", int'(err_udf & err_ovf), 1);

    // Reset while the barrier is up
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    cycle(1, 0, 0);
    check("s6_open", int'(gate_open), 1);
    cycle(1, 0, 0, 0);
    check("s6_gate", int'(gate_open), 0);
    check("s6_count", int'(count), 0);
    cycle(1, 0, 0);
    check("s6_idle_regrant", int'(gate_open), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rq = ($urandom_range(0, 3) != 0);
      ci = ((m_phase == 1) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 39) == 0);
      co = ($urandom_range(0, 5) == 0);
      if (ci && co && (m_cnt == CAP || m_cnt == 0)) co = 1'b0;
      rn = ($urandom_range(0, 299) != 0);
      cycle(rq, ci, co, rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
